// File: rtl/node_vc_ingress.sv
// rtl/node_vc_ingress.sv - per-VC ingress FIFOs with credit return and config chain
module node_vc_ingress #(
  parameter int HADDR      = 0,
  parameter int ID_WIDTH   = 11,
  parameter int NVCS       = 2,
  parameter int DEPTH      = 4,
  parameter int FLIT_WIDTH = 36,
  parameter int VC_LSB     = 0,
  localparam int LOG_NVCS  = (NVCS > 1) ? $clog2(NVCS) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       flit_in_valid,
  input  logic [FLIT_WIDTH-1:0]      flit_in,
  input  logic [ID_WIDTH-1:0]        nexthop_in,
  output logic                       flit_ack,
  output logic [NVCS*FLIT_WIDTH-1:0] flit_out,
  output logic [NVCS-1:0]            flit_out_valid,
  input  logic [NVCS-1:0]            dequeue,
  output logic                       credit_out_valid,
  output logic [LOG_NVCS-1:0]        credit_out,
  input  logic                       credit_dequeue,
  input  logic                       config_in_valid,
  input  logic [15:0]                config_in,
  output logic                       config_out_valid,
  output logic [15:0]                config_out,
  output logic                       error,
  output logic                       is_quiescent
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ID_WIDTH-1:0] HADDR_L = ID_WIDTH'(HADDR);
  localparam logic [CW-1:0]       DEPTH_L = CW'(DEPTH);

  typedef enum logic {CFG_LOAD, CFG_PASS} cfg_state_e;

  logic [FLIT_WIDTH-1:0] mem_q [NVCS][DEPTH];
  logic [FLIT_WIDTH-1:0] mem_d [NVCS][DEPTH];
  logic [PW-1:0]         rptr_q [NVCS], rptr_d [NVCS];
  logic [PW-1:0]         wptr_q [NVCS], wptr_d [NVCS];
  logic [CW-1:0]         cnt_q  [NVCS], cnt_d  [NVCS];
  logic [CW-1:0]         cred_q [NVCS], cred_d [NVCS];
  logic                  err_q, err_d;
  logic                  port_en_q, port_en_d;
  cfg_state_e            state_q, state_d;
  logic [15:0]           cfg_out_q, cfg_out_d;
  logic                  cfg_vld_q, cfg_vld_d;

  logic [LOG_NVCS-1:0] vc, cred_sel;
  logic                match, tgt_full, cred_any, quiet;
  logic [NVCS-1:0]     push, pop, pop_req, nonempty, cred_dec;

  always_comb begin
    vc       = flit_in[VC_LSB +: LOG_NVCS];
    match    = flit_in_valid & enable & port_en_q & (nexthop_in == HADDR_L);
    // A VC field with no matching FIFO leaves tgt_full set, so it is dropped as a fault
    tgt_full = 1'b1;
    for (int v = 0; v < NVCS; v++) begin
      if (vc == LOG_NVCS'(v)) tgt_full = (cnt_q[v] == DEPTH_L);
    end
    flit_ack = match & ~tgt_full;

    cred_any = 1'b0;
    cred_sel = '0;
    for (int v = NVCS-1; v >= 0; v--) begin
      if (cred_q[v] != '0) begin
        cred_any = 1'b1;
        cred_sel = LOG_NVCS'(v);
      end
    end

    quiet    = 1'b1;
    err_d    = err_q | (match & ~flit_ack);
    mem_d    = mem_q;
    flit_out = '0;
    for (int v = 0; v < NVCS; v++) begin
      nonempty[v] = (cnt_q[v] != '0);
      push[v]     = flit_ack & (vc == LOG_NVCS'(v));
      pop_req[v]  = dequeue[v] & enable;
      pop[v]      = pop_req[v] & nonempty[v];
      cred_dec[v] = credit_dequeue & enable & cred_any & (cred_sel == LOG_NVCS'(v));
      wptr_d[v]   = wptr_q[v] + PW'(push[v]);
      rptr_d[v]   = rptr_q[v] + PW'(pop[v]);
      cnt_d[v]    = cnt_q[v] + CW'(push[v]) - CW'(pop[v]);
      cred_d[v]   = cred_q[v] + CW'(pop[v]) - CW'(cred_dec[v]);
      if (push[v]) mem_d[v][wptr_q[v]] = flit_in;
      if (pop_req[v] & ~nonempty[v]) err_d = 1'b1;
      if (nonempty[v] || (cred_q[v] != '0)) quiet = 1'b0;
      flit_out[v*FLIT_WIDTH +: FLIT_WIDTH] = mem_q[v][rptr_q[v]];
    end
  end

  // The first config word is consumed locally; everything after is forwarded
  always_comb begin
    state_d   = state_q;
    port_en_d = port_en_q;
    cfg_out_d = cfg_out_q;
    cfg_vld_d = cfg_vld_q;
    case (state_q)
      CFG_LOAD: begin
        cfg_vld_d = 1'b0;
        if (config_in_valid) begin
          port_en_d = config_in[0];
          state_d   = CFG_PASS;
        end
      end
      CFG_PASS: begin
        cfg_out_d = config_in;
        cfg_vld_d = config_in_valid;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NVCS; v++) begin
        rptr_q[v] <= '0;
        wptr_q[v] <= '0;
        cnt_q[v]  <= '0;
        cred_q[v] <= '0;
      end
      err_q     <= 1'b0;
      port_en_q <= 1'b0;
      state_q   <= CFG_LOAD;
      cfg_out_q <= '0;
      cfg_vld_q <= 1'b0;
    end else begin
      for (int v = 0; v < NVCS; v++) begin
        rptr_q[v] <= rptr_d[v];
        wptr_q[v] <= wptr_d[v];
        cnt_q[v]  <= cnt_d[v];
        cred_q[v] <= cred_d[v];
      end
      err_q     <= err_d;
      port_en_q <= port_en_d;
      state_q   <= state_d;
      cfg_out_q <= cfg_out_d;
      cfg_vld_q <= cfg_vld_d;
    end
  end

  assign flit_out_valid   = nonempty;
  assign credit_out_valid = cred_any;
  assign credit_out       = cred_sel;
  assign config_out_valid = cfg_vld_q;
  assign config_out       = cfg_out_q;
  assign error            = err_q;
  assign is_quiescent     = quiet;
endmodule

// File: tb/tb_node_vc_ingress.sv
// tb/tb_node_vc_ingress.sv - directed and random checks of node_vc_ingress
module tb_node_vc_ingress;
  logic        clock, reset, enable, flit_in_valid, flit_ack;
  logic [35:0] flit_in;
  logic [10:0] nexthop_in;
  logic [71:0] flit_out;
  logic [1:0]  flit_out_valid, dequeue;
  logic        credit_out_valid, credit_dequeue;
  logic [0:0]  credit_out;
  logic        config_in_valid, config_out_valid, error, is_quiescent;
  logic [15:0] config_in, config_out;

  node_vc_ingress dut (
    .clock(clock), .reset(reset), .enable(enable),
    .flit_in_valid(flit_in_valid), .flit_in(flit_in), .nexthop_in(nexthop_in),
    .flit_ack(flit_ack), .flit_out(flit_out), .flit_out_valid(flit_out_valid),
    .dequeue(dequeue), .credit_out_valid(credit_out_valid), .credit_out(credit_out),
    .credit_dequeue(credit_dequeue), .config_in_valid(config_in_valid),
    .config_in(config_in), .config_out_valid(config_out_valid),
    .config_out(config_out), .error(error), .is_quiescent(is_quiescent)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [35:0] mq [2][$];
  int          pc [2];
  bit          err_m, pen_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    bit cv = 0;
    int cs = 0;
    for (int v = 1; v >= 0; v--) if (pc[v] > 0) begin cv = 1; cs = v; end
    for (int v = 0; v < 2; v++) begin
      chk({tag, "/valid"}, 64'(flit_out_valid[v]), 64'(mq[v].size() != 0));
      if (mq[v].size() != 0) chk({tag, "/head"}, 64'(flit_out[v*36 +: 36]), 64'(mq[v][0]));
    end
    chk({tag, "/cvalid"}, 64'(credit_out_valid), 64'(cv));
    if (cv) chk({tag, "/cvc"}, 64'(credit_out), 64'(cs));
    chk({tag, "/error"}, 64'(error), 64'(err_m));
    chk({tag, "/quiet"}, 64'(is_quiescent),
        64'(mq[0].size() == 0 && mq[1].size() == 0 && pc[0] == 0 && pc[1] == 0));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "/fov"},   64'(flit_out_valid), 64'(0));
    chk({tag, "/cov"},   64'(credit_out_valid), 64'(0));
    chk({tag, "/quiet"}, 64'(is_quiescent), 64'(1));
    chk({tag, "/error"}, 64'(error), 64'(0));
    chk({tag, "/cfgv"},  64'(config_out_valid), 64'(0));
    chk({tag, "/cfgo"},  64'(config_out), 64'(0));
  endtask

  // One clock of stimulus; the model applies the legality rules to queues and counters
  task automatic step(input bit en, input bit fv, input logic [35:0] f, input logic [10:0] nh,
                      input logic [1:0] dq, input bit cdq, output bit ack);
    int  vc, cs;
    bit  match, exp_ack, cv;
    enable = en; flit_in_valid = fv; flit_in = f; nexthop_in = nh;
    dequeue = dq; credit_dequeue = cdq;
    #1;
    vc      = int'(f[0]);
    match   = fv && en && pen_m && (nh == 11'd0);
    exp_ack = match && (mq[vc].size() < 4);
    ack     = flit_ack;
    chk("flit_ack", 64'(flit_ack), 64'(exp_ack));
    cv = 0; cs = 0;
    for (int v = 1; v >= 0; v--) if (pc[v] > 0) begin cv = 1; cs = v; end
    if (en) begin
      for (int v = 0; v < 2; v++) begin
        if (dq[v]) begin
          if (mq[v].size() > 0) begin
            void'(mq[v].pop_front());
            pc[v]++;
          end else err_m = 1;
        end
      end
      if (cdq && cv) pc[cs]--;
      if (match && !exp_ack) err_m = 1;
      if (exp_ack) mq[vc].push_back(f);
    end
    @(posedge clock); #1;
    check_state("state");
  endtask

  task automatic idle();
    bit a;
    step(1, 0, '0, '0, 2'b00, 0, a);
  endtask

  task automatic clear_model();
    mq[0].delete(); mq[1].delete();
    pc[0] = 0; pc[1] = 0;
    err_m = 0; pen_m = 0;
  endtask

  task automatic load_cfg();
    config_in_valid = 1; config_in = 16'h0001;
    idle();
    config_in_valid = 0; config_in = 16'h0000;
    pen_m = 1;
  endtask

  task automatic do_reset(input string tag);
    enable = 0; flit_in_valid = 0; dequeue = 0; credit_dequeue = 0;
    reset = 0;
    #1;
    reset_checks(tag);
    clear_model();
    @(negedge clock);
    reset = 1;
    @(posedge clock); #1;
  endtask

  initial begin
    bit          a, en, fv, cdq;
    int          acks, vc;
    logic [1:0]  dq;
    logic [10:0] nh;
    logic [35:0] f;
    reset = 0; enable = 0; flit_in_valid = 0; flit_in = '0; nexthop_in = '0;
    dequeue = '0; credit_dequeue = 0; config_in_valid = 0; config_in = '0;
    clear_model();
    repeat (2) @(posedge clock);
    #1;
    reset_checks("reset");
    @(negedge clock);
    reset = 1;
    @(posedge clock); #1;

    // Port disabled until configured: a matching flit is ignored
    step(1, 1, 36'h10, 11'd0, 2'b00, 0, a);
    chk("unconfigured_ack", 64'(a), 64'(0));

    config_in_valid = 1; config_in = 16'h0001;
    idle();
    pen_m = 1;
    chk("cfg_first_v", 64'(config_out_valid), 64'(0));
    config_in = 16'h1234;
    idle();
    chk("cfg_1234_v", 64'(config_out_valid), 64'(1));
    chk("cfg_1234_d", 64'(config_out), 64'h1234);
    config_in = 16'hBEEF;
    idle();
    chk("cfg_beef_v", 64'(config_out_valid), 64'(1));
    chk("cfg_beef_d", 64'(config_out), 64'hBEEF);
    config_in_valid = 0; config_in = 16'h0000;
    idle();
    chk("cfg_idle_v", 64'(config_out_valid), 64'(0));

    step(1, 1, 36'h5, 11'd1, 2'b00, 0, a);
    chk("nomatch_ack", 64'(a), 64'(0));
    chk("nomatch_quiet", 64'(is_quiescent), 64'(1));

    acks = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 1, {32'(i + 100), 4'b0001}, 11'd0, 2'b00, 0, a);
      acks += int'(a);
    end
    chk("overflow_acks", 64'(acks), 64'(4));
    chk("overflow_fov", 64'(flit_out_valid), 64'(2'b10));
    chk("overflow_err", 64'(error), 64'(1));
    repeat (4) step(1, 0, '0, '0, 2'b10, 0, a);
    repeat (4) step(1, 0, '0, '0, 2'b00, 1, a);
    do_reset("reset2");
    load_cfg();

    step(1, 1, 36'hA0, 11'd0, 2'b00, 0, a);
    step(1, 1, 36'hB1, 11'd0, 2'b00, 0, a);
    step(1, 0, '0, '0, 2'b10, 0, a);
    step(1, 0, '0, '0, 2'b01, 0, a);
    chk("credit_first", 64'(credit_out), 64'(0));
    step(1, 0, '0, '0, 2'b00, 1, a);
    chk("credit_second", 64'(credit_out), 64'(1));
    step(1, 0, '0, '0, 2'b00, 1, a);
    chk("credit_quiet", 64'(is_quiescent), 64'(1));

    // Push, pop and credit return all on VC0 in one cycle at count 2
    for (int i = 0; i < 3; i++) step(1, 1, {32'(i + 200), 4'b0000}, 11'd0, 2'b00, 0, a);
    step(1, 0, '0, '0, 2'b01, 0, a);
    step(1, 1, 36'hC0, 11'd0, 2'b01, 1, a);
    chk("simul_ack", 64'(a), 64'(1));
    chk("simul_cvalid", 64'(credit_out_valid), 64'(1));
    repeat (2) step(1, 0, '0, '0, 2'b01, 0, a);
    chk("simul_drained", 64'(flit_out_valid), 64'(0));
    repeat (3) step(1, 0, '0, '0, 2'b00, 1, a);

    step(1, 1, 36'hD1, 11'd0, 2'b00, 0, a);
    step(0, 1, 36'hE1, 11'd0, 2'b11, 1, a);
    chk("frozen_err", 64'(error), 64'(0));

    for (int i = 0; i < 400; i++) begin
      vc  = int'($urandom_range(0, 1));
      en  = ($urandom_range(0, 9) != 0);
      nh  = ($urandom_range(0, 7) == 0) ? 11'd1 : 11'd0;
      fv  = ($urandom_range(0, 1) == 1) && (mq[vc].size() + pc[vc] < 4);
      dq[0] = ($urandom_range(0, 1) == 1) && (mq[0].size() > 0);
      dq[1] = ($urandom_range(0, 1) == 1) && (mq[1].size() > 0);
      cdq = ($urandom_range(0, 1) == 1);
      f   = {4'($urandom), 31'($urandom), 1'(vc)};
      step(en, fv, f, nh, dq, cdq, a);
    end

    for (int i = 0; i < 40; i++) begin
      if (mq[0].size() == 0 && mq[1].size() == 0 && pc[0] == 0 && pc[1] == 0) break;
      dq = {mq[1].size() > 0, mq[0].size() > 0};
      step(1, 0, '0, '0, dq, 1, a);
    end
    chk("drain_quiet", 64'(is_quiescent), 64'(1));
    step(1, 0, '0, '0, 2'b10, 0, a);
    chk("empty_pop_err", 64'(error), 64'(1));

    step(1, 1, 36'hF0, 11'd0, 2'b00, 0, a);
    step(1, 1, 36'hF1, 11'd0, 2'b00, 0, a);
    step(1, 1, 36'hF2, 11'd0, 2'b00, 0, a);
    #3;
    do_reset("reset_mid");
    load_cfg();
    step(1, 1, 36'h123457, 11'd0, 2'b00, 0, a);
    chk("post_reset_ack", 64'(a), 64'(1));
    chk("post_reset_fov", 64'(flit_out_valid), 64'(2'b10));
    chk("post_reset_head", 64'(flit_out[71:36]), 64'h123457);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
